// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: a WIDTH-bit operand pair is processed CHUNK
// bits per clock through a ripple of full-adder cells. The carry is held in a
// register between steps. Results are registered and only update on completion.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int N      = WIDTH / CHUNK;
    localparam int STEP_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [STEP_W-1:0] LAST = STEP_W'(N - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_param
            $error("serial_add_sub: CHUNK must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0]  op_a, op_b, res, res_next;
    logic              carry;
    logic [STEP_W-1:0] step;
    logic [CHUNK-1:0]  ch_a, ch_b, ch_s;
    logic [CHUNK:0]    c;
    logic              last, accept;

    assign last   = (step == LAST);
    assign accept = start && (state != RUN);
    assign ch_a   = op_a[step*CHUNK +: CHUNK];
    assign ch_b   = op_b[step*CHUNK +: CHUNK];
    assign c[0]   = carry;

    // One chunk of ripple-carry full adders, re-used every RUN step.
    genvar i;
    generate
        for (i = 0; i < CHUNK; i++) begin : g_fa
            full_adder u_fa (
                .a    (ch_a[i]),
                .b    (ch_b[i]),
                .cin  (c[i]),
                .s    (ch_s[i]),
                .cout (c[i+1])
            );
        end
    endgenerate

    // Result register with the current chunk merged in; feeds both the
    // internal register and the output register on the final step.
    always_comb begin
        res_next = res;
        res_next[step*CHUNK +: CHUNK] = ch_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic; start is only honoured outside RUN.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Operand capture, per-step accumulation, and the output registers that
    // load only on the edge entering DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            step  <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            if (accept) begin
                op_a  <= a;
                op_b  <= sub ? ~b : b;
                carry <= sub;
                step  <= '0;
            end else if (state == RUN) begin
                res   <= res_next;
                carry <= c[CHUNK];
                step  <= last ? '0 : step + 1'b1;
                if (last) begin
                    s    <= res_next;
                    cout <= c[CHUNK];
                    ovf  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                            (res_next[WIDTH-1] != op_a[WIDTH-1]);
                end
            end
        end
    end
endmodule

// File: tb/tb_serial_add_sub.sv
// Bench for serial_add_sub: three instances (CHUNK=4, 1, 16) at WIDTH=16,
// expected results queued at issue time and compared when done pulses.

module tb_serial_add_sub;
    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        start_v = '0;
    logic              sub = 1'b0;
    logic [15:0]       a = '0, b = '0;
    logic [2:0]        busy_v, done_v, cout_v, ovf_v;
    logic [2:0][15:0]  s_v;

    int   cyc = 0;
    int   errors = 0, checks = 0;
    exp_t q[$];
    logic [15:0] prev_s;

    always #5 clk = ~clk;

    // Cycle counter for latency and spacing measurements.
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_sub #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .a(a), .b(b),
        .busy(busy_v[0]), .done(done_v[0]), .s(s_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));
    serial_add_sub #(.WIDTH(16), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .a(a), .b(b),
        .busy(busy_v[1]), .done(done_v[1]), .s(s_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));
    serial_add_sub #(.WIDTH(16), .CHUNK(16)) dut2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .a(a), .b(b),
        .busy(busy_v[2]), .done(done_v[2]), .s(s_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

    // Golden model built on signed/unsigned integer arithmetic.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic m);
        exp_t e;
        int sx, sy, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (m) begin
            r      = sx - sy;
            e.s    = x - y;
            e.cout = (x >= y);
        end else begin
            r      = sx + sy;
            e.s    = x + y;
            e.cout = ((32'(x) + 32'(y)) > 32'd65535);
        end
        e.ovf = (r > 32767) || (r < -32768);
        return e;
    endfunction

    task automatic issue(input int d, input logic [15:0] x, input logic [15:0] y, input logic m);
        a = x; b = y; sub = m;
        start_v[d] = 1'b1;
        q.push_back(model(x, y, m));
    endtask

    // Advance until done (or limit); n = cycles after the start edge.
    task automatic wait_done(input int d, input int limit, output int n, output int nb);
        n = 0; nb = 0;
        while (!done_v[d] && n < limit) begin
            if (busy_v[d]) nb++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        checks++;
        if ({busy_v, done_v, cout_v, ovf_v, s_v} !== '0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b cout=%b ovf=%b s=%h, want all zero",
                     busy_v, done_v, cout_v, ovf_v, s_v);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Single op on dut0 with latency, busy length and result checks.
    task automatic run_single(input string name, input logic [15:0] x, input logic [15:0] y, input logic m);
        int n, nb;
        exp_t e;
        issue(0, x, y, m);
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 20, n, nb);
        checks++;
        if (!done_v[0] || q.size() == 0) begin
            errors++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, n);
            q.delete();
            return;
        end
        e = q.pop_front();
        if ({s_v[0], cout_v[0], ovf_v[0]} !== e) begin
            errors++;
            $display("FAIL %s_result: got s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b",
                     name, s_v[0], cout_v[0], ovf_v[0], e.s, e.cout, e.ovf);
        end
        checks++;
        if (n !== 4 || nb !== 4 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL %s_timing: got latency=%0d busy_cycles=%0d busy_at_done=%b, want 4 4 0",
                     name, n, nb, busy_v[0]);
        end
        prev_s = e.s;
        @(negedge clk);
    endtask

    task automatic test_add;
        run_single("add_1234_4321", 16'h1234, 16'h4321, 1'b0);
        run_single("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0);
        run_single("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0);
    endtask

    task automatic test_sub;
        run_single("sub_0005_0007", 16'h0005, 16'h0007, 1'b1);
        run_single("sub_8000_0001", 16'h8000, 16'h0001, 1'b1);
    endtask

    // A second start during RUN must be ignored and s must hold meanwhile.
    task automatic test_start_ignored;
        int n;
        bit held;
        exp_t e;
        held = 1'b1;
        issue(0, 16'h00F0, 16'h0F0F, 1'b0);
        @(negedge clk);
        start_v[0] = 1'b0;
        if (s_v[0] !== prev_s) held = 1'b0;
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start_v[0] = 1'b1;
        if (s_v[0] !== prev_s) held = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 2;
        while (!done_v[0] && n < 20) begin
            if (s_v[0] !== prev_s) held = 1'b0;
            @(negedge clk);
            n++;
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL run_s_hold: s changed during RUN, want %h held", prev_s);
        end
        checks++;
        if (!done_v[0] || q.size() == 0) begin
            errors++;
            $display("FAIL ignore_timeout: no done after %0d cycles", n);
            q.delete();
            return;
        end
        e = q.pop_front();
        if ({s_v[0], cout_v[0], ovf_v[0]} !== e || n !== 4) begin
            errors++;
            $display("FAIL ignore_result: got s=%h cout=%b ovf=%b lat=%0d, want s=%h cout=%b ovf=%b lat=4",
                     s_v[0], cout_v[0], ovf_v[0], n, e.s, e.cout, e.ovf);
        end
        prev_s = e.s;
        @(negedge clk);
        checks++;
        if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL ignore_idle: got done=%b busy=%b, want 0 0", done_v[0], busy_v[0]);
        end
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        issue(0, 16'h1357, 16'h2468, 1'b0);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        q.delete();
        checks++;
        if ({busy_v[0], done_v[0], s_v[0], cout_v[0], ovf_v[0]} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b s=%h cout=%b ovf=%b, want all zero",
                     busy_v[0], done_v[0], s_v[0], cout_v[0], ovf_v[0]);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_v[0]) saw_done = 1'b1;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done_v[0]) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            errors++;
            $display("FAIL reset_no_done: got a done pulse after abort, want none");
        end
        run_single("after_reset", 16'hC000, 16'h4000, 1'b0);
    endtask

    // start held high: back-to-back random ops with latency/spacing checks.
    task automatic test_back_to_back(input int d, input int nsteps, input int cnt);
        int n, c0, prev_done;
        exp_t e;
        c0 = cyc;
        prev_done = 0;
        issue(d, 16'($urandom()), 16'($urandom()), 1'($urandom()));
        for (int i = 0; i < cnt; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done_v[d] && n < nsteps + 5);
            checks++;
            if (!done_v[d] || q.size() == 0) begin
                errors++;
                $display("FAIL b2b_timeout_d%0d: op %0d no done after %0d cycles", d, i, n);
                start_v[d] = 1'b0;
                q.delete();
                repeat (nsteps + 3) @(negedge clk);
                return;
            end
            if (i == 0) begin
                if (cyc - c0 - 1 !== nsteps) begin
                    errors++;
                    $display("FAIL b2b_latency_d%0d: got %0d, want %0d", d, cyc - c0 - 1, nsteps);
                end
            end else if (cyc - prev_done !== nsteps + 1 || busy_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL b2b_spacing_d%0d: op %0d got %0d busy=%b, want %0d busy=0",
                         d, i, cyc - prev_done, busy_v[d], nsteps + 1);
            end
            prev_done = cyc;
            e = q.pop_front();
            checks++;
            if ({s_v[d], cout_v[d], ovf_v[d]} !== e) begin
                errors++;
                $display("FAIL b2b_result_d%0d: op %0d got s=%h cout=%b ovf=%b, want s=%h cout=%b ovf=%b",
                         d, i, s_v[d], cout_v[d], ovf_v[d], e.s, e.cout, e.ovf);
            end
            if (i < cnt - 1) issue(d, 16'($urandom()), 16'($urandom()), 1'($urandom()));
            else             start_v[d] = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        prev_s = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back(1, 16, 500);
        test_back_to_back(2, 1, 500);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
